bmp_pixel_writer: RTL and testbench

- Sink for the RGB pixel-processing stage.
- Accepts processed 8-bit R/G/B pixels on a one-cycle `done_in` strobe and buffers them in a small FIFO.
- Serializes them into a BMP-ordered byte stream (B, G, R per pixel, optional zero padding to a 4-byte row boundary) over a valid/ready handshake.
- Counts rows and columns and flags end of frame; sits between the pixel processor outputs and the image-file/memory writer.

---
 rtl/bmp_pixel_writer.sv | 167 ++++++++++++++++
 tb/tb_bmp_pixel_writer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bmp_pixel_writer.sv
// Pixel sink: buffers {R,G,B} pixels in a small FIFO and streams them as BMP-ordered bytes (B, G, R).
// Optional feature macro BMP_ROW_PAD_EN: zero-pads every row to a 4-byte boundary.
module bmp_pixel_writer #(
    parameter int WIDTH  = 5,
    parameter int HEIGHT = 2,
    parameter int DEPTH  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       done_in,
    input  logic [7:0] red_in,
    input  logic [7:0] green_in,
    input  logic [7:0] blue_in,
    input  logic       byte_ready,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       frame_done,
    output logic       overflow,
    output logic       busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        EMIT_B = 3'd1,
        EMIT_G = 3'd2,
        EMIT_R = 3'd3,
`ifdef BMP_ROW_PAD_EN
        PAD    = 3'd4,
`endif
        DONE   = 3'd5
    } state_t;

    state_t        state;
    logic [23:0]   mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [23:0]   head;
    logic [15:0]   hold;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic          hs;
    logic          r_acc;
    logic          last_col;
    logic          last_row;
    logic          row_end;
    logic          frame_end;
    logic          seek;

    // FIFO: pointers carry a wrap bit so full and empty are distinguishable
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push  = done_in && !full;
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {red_in, green_in, blue_in};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (done_in && full) overflow <= 1'b1;
        end
    end

    assign hs       = byte_valid && byte_ready;
    assign r_acc    = (state == EMIT_R) && hs;
    assign last_col = (col == COL_LAST);
    assign last_row = (row == ROW_LAST);

`ifdef BMP_ROW_PAD_EN
    localparam int PAD_N = (4 - ((3 * WIDTH) % 4)) % 4;
    localparam logic [1:0] PAD_LAST = 2'((PAD_N == 0) ? 0 : PAD_N - 1);

    logic [1:0] pad_cnt;
    logic       to_pad;
    logic       pad_end;

    assign to_pad  = r_acc && last_col && (PAD_N != 0);
    assign pad_end = (state == PAD) && hs && (pad_cnt == PAD_LAST);
    assign row_end = (r_acc && last_col && (PAD_N == 0)) || pad_end;
`else
    assign row_end = r_acc && last_col;
`endif

    // seek: a pixel (and possibly a row) just completed and the frame continues
    assign seek      = (r_acc && !last_col) || (row_end && !last_row);
    assign frame_end = row_end && last_row;
    assign pop       = !empty && ((state == IDLE) || seek);
    assign busy      = !empty || byte_valid;

    always_ff @(posedge clk) begin
        if (pop) hold <= head[23:8];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            byte_out   <= '0;
            byte_valid <= 1'b0;
            frame_done <= 1'b0;
            col        <= '0;
            row        <= '0;
`ifdef BMP_ROW_PAD_EN
            pad_cnt    <= '0;
`endif
        end else begin
            frame_done <= 1'b0;
            if (r_acc) col <= last_col ? '0 : col + 1'b1;
            if (row_end) row <= last_row ? '0 : row + 1'b1;

            if (pop) begin
                byte_out   <= head[7:0];
                byte_valid <= 1'b1;
                state      <= EMIT_B;
            end else if (frame_end) begin
                byte_out   <= '0;
                byte_valid <= 1'b0;
                frame_done <= 1'b1;
                state      <= DONE;
            end else if (seek) begin
                byte_out   <= '0;
                byte_valid <= 1'b0;
                state      <= IDLE;
            end else begin
                case (state)
                    EMIT_B: if (hs) begin
                        byte_out <= hold[7:0];
                        state    <= EMIT_G;
                    end
                    EMIT_G: if (hs) begin
                        byte_out <= hold[15:8];
                        state    <= EMIT_R;
                    end
`ifdef BMP_ROW_PAD_EN
                    EMIT_R: if (to_pad) begin
                        byte_out <= '0;
                        pad_cnt  <= '0;
                        state    <= PAD;
                    end
                    PAD: if (hs) pad_cnt <= pad_cnt + 1'b1;
`endif
                    DONE: begin
                        row   <= '0;
                        col   <= '0;
                        state <= IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_bmp_pixel_writer.sv
// Scoreboard bench for bmp_pixel_writer: expected bytes queued at stimulus time, checked by a monitor.
module tb_bmp_pixel_writer;
    localparam int WIDTH  = 5;
    localparam int HEIGHT = 2;
    localparam int DEPTH  = 4;
`ifdef BMP_ROW_PAD_EN
    localparam int PAD_N = 1;
`else
    localparam int PAD_N = 0;
`endif
    localparam int FRAME_BYTES = HEIGHT * (3 * WIDTH + PAD_N);

    logic       clk = 1'b0;
    logic       reset;
    logic       done_in;
    logic [7:0] red_in;
    logic [7:0] green_in;
    logic [7:0] blue_in;
    logic       byte_ready;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       frame_done;
    logic       overflow;
    logic       busy;

    always #5 clk = ~clk;

    bmp_pixel_writer #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .done_in(done_in),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .byte_ready(byte_ready), .byte_out(byte_out), .byte_valid(byte_valid),
        .frame_done(frame_done), .overflow(overflow), .busy(busy)
    );

    logic [7:0] exp_q[$];
    int   exp_col = 0;
    int   rx_cnt  = 0;
    int   fd_cnt  = 0;
    int   passed  = 0;
    int   total   = 0;
    logic prev_fd = 1'b0;

    task automatic check(input string nm, input int act, input int want);
        total++;
        if (act == want) passed++;
        else $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", nm, act, act, want, want);
    endtask

    function automatic void enq_px(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        exp_q.push_back(b);
        exp_q.push_back(g);
        exp_q.push_back(r);
        exp_col++;
        if (exp_col == WIDTH) begin
            exp_col = 0;
            for (int i = 0; i < PAD_N; i++) exp_q.push_back(8'h00);
        end
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_px(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                           input bit accepted);
        red_in   = r;
        green_in = g;
        blue_in  = b;
        done_in  = 1'b1;
        @(posedge clk);
        #1;
        done_in = 1'b0;
        if (accepted) enq_px(r, g, b);
    endtask

    task automatic do_reset();
        done_in    = 1'b0;
        byte_ready = 1'b1;
        red_in     = 8'h00;
        green_in   = 8'h00;
        blue_in    = 8'h00;
        reset      = 1'b1;
        tick(2);
        exp_q.delete();
        exp_col = 0;
        rx_cnt  = 0;
        fd_cnt  = 0;
        reset   = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 500) begin
            tick(1);
            n++;
        end
        check(nm, exp_q.size(), 0);
        tick(3);
    endtask

    // Monitor: every accepted byte is compared against the head of the expected queue
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (byte_valid && byte_ready) begin
                rx_cnt++;
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL extra_byte: got 0x%02h, required no byte", byte_out);
                end else begin
                    check("byte", int'(byte_out), int'(exp_q.pop_front()));
                end
            end
            if (frame_done) begin
                fd_cnt++;
                check("fd_single_cycle", int'(prev_fd), 0);
                check("fd_byte_count", rx_cnt, fd_cnt * FRAME_BYTES);
            end
        end
        prev_fd = frame_done;
    end

    initial begin
        int n;

        // reset state
        do_reset();
        check("rst_byte_valid", byte_valid, 0);
        check("rst_byte_out", byte_out, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_overflow", overflow, 0);
        check("rst_busy", busy, 0);

        // single pixel and two-cycle latency
        push_px(8'h11, 8'h22, 8'h33, 1'b1);
        check("lat_not_yet_valid", byte_valid, 0);
        check("lat_busy", busy, 1);
        tick(1);
        check("lat_valid", byte_valid, 1);
        check("lat_first_byte", byte_out, 8'h33);
        drain("single_drain");
        check("single_rx", rx_cnt, 3);
        check("single_idle_busy", busy, 0);

        // two frames back to back
        do_reset();
        for (int i = 0; i < 2 * WIDTH * HEIGHT; i++) begin
            push_px(8'(16 + i), 8'(64 + i), 8'(128 + i), 1'b1);
            tick(3);
        end
        drain("frames_drain");
        check("frames_fd_count", fd_cnt, 2);
        check("frames_rx", rx_cnt, 2 * FRAME_BYTES);
        check("frames_busy", busy, 0);
        check("frames_no_overflow", overflow, 0);

        // backpressure during the G byte
        do_reset();
        byte_ready = 1'b0;
        push_px(8'hA1, 8'hA2, 8'hA3, 1'b1);
        tick(1);
        check("bp_b_valid", byte_valid, 1);
        check("bp_b_value", byte_out, 8'hA3);
        byte_ready = 1'b1;
        tick(1);
        byte_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_g_hold", byte_out, 8'hA2);
            check("bp_g_valid", byte_valid, 1);
            tick(1);
        end
        byte_ready = 1'b1;
        drain("bp_drain");
        check("bp_rx", rx_cnt, 3);

        // overflow: one pixel held in the FSM, then a burst of six into the FIFO
        do_reset();
        byte_ready = 1'b0;
        push_px(8'h01, 8'h02, 8'h03, 1'b1);
        tick(1);
        for (int k = 0; k < 6; k++) begin
            push_px(8'(8'h50 + k), 8'(8'h60 + k), 8'(8'h70 + k), k < 4);
            check("ovf_flag", overflow, (k >= 4) ? 1 : 0);
        end
        byte_ready = 1'b1;
        drain("ovf_drain");
        check("ovf_rx", rx_cnt, 15 + PAD_N);
        check("ovf_sticky", overflow, 1);
        do_reset();
        check("ovf_cleared", overflow, 0);

        // reset during EMIT_G of pixel 3, then a clean frame
        for (int i = 0; i < 4; i++) begin
            push_px(8'(16 + i), 8'(64 + i), 8'(128 + i), 1'b1);
            if (i < 3) tick(3);
        end
        n = 0;
        while (!(byte_valid && byte_out == 8'h43) && n < 20) begin
            tick(1);
            n++;
        end
        byte_ready = 1'b0;
        check("mid_g3_seen", byte_out, 8'h43);
        #2 reset = 1'b1;
        #1;
        check("mid_async_valid", byte_valid, 0);
        check("mid_async_out", byte_out, 0);
        check("mid_async_busy", busy, 0);
        check("mid_async_fd", frame_done, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        exp_col    = 0;
        rx_cnt     = 0;
        fd_cnt     = 0;
        byte_ready = 1'b1;
        reset      = 1'b0;
        for (int i = 0; i < WIDTH * HEIGHT; i++) begin
            push_px(8'(8'hC0 + i), 8'(8'hD0 + i), 8'(8'hE0 + i), 1'b1);
            tick(3);
        end
        drain("mid_drain");
        check("mid_fd_count", fd_cnt, 1);
        check("mid_rx", rx_cnt, FRAME_BYTES);
        check("mid_busy", busy, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not complete, %0d of %0d passed", passed, total);
        $fatal(1, "timeout");
    end
endmodule
